// File: rtl/fwd_pkg.sv
// Shared encodings and shadow-stage record for the forwarding/stall controller.
package fwd_pkg;

    typedef enum logic [1:0] {
        SEL_RF = 2'd0,
        SEL_M  = 2'd1,
        SEL_W  = 2'd2,
        SEL_E  = 2'd3
    } fwd_sel_t;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Control half of a shadow stage; addresses live beside it because their width is a module parameter.
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [1:0] tnew;
    } stage_t;

    function automatic logic [1:0] tnew_step(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Loadable down-counter tracking how long the mult/div unit stays occupied.
module md_busy_counter #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_div,
    output logic o_busy
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_busy = (r_count != '0);

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Shadow E/M/W tracker that produces the D-stage stall and the D/E/M bypass selects.
// Define FWD_MD_UNIT_EN to add the mult/div busy interlock.
module fwd_stall_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      d_valid,
    input  logic [NUM_SRC*REG_AW-1:0] d_src_addr,
    input  logic [NUM_SRC*2-1:0]      d_src_tuse,
    input  logic [REG_AW-1:0]         d_dst_addr,
    input  logic                      d_dst_we,
    input  logic [1:0]                d_dst_tnew,
    input  logic                      d_md_start,
    input  logic                      d_md_div,
    input  logic                      d_md_use,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      fwd_d_sel,
    output logic [NUM_SRC*2-1:0]      fwd_e_sel,
    output logic [1:0]                fwd_m_sel,
    output logic                      md_busy
);
    localparam int RT_IDX = (NUM_SRC > 1) ? 1 : 0;

    stage_t                         r_e, r_m, r_w;
    logic [REG_AW-1:0]              r_e_dst, r_m_dst, r_w_dst, r_m_rt;
    logic [NUM_SRC-1:0][REG_AW-1:0] r_e_src;
    logic [NUM_SRC-1:0][REG_AW-1:0] w_d_src;
    logic [NUM_SRC-1:0]             w_hazard;
    logic                           w_data_stall, w_md_stall;

    function automatic logic hit(input stage_t s, input logic [REG_AW-1:0] dst,
                                 input logic [REG_AW-1:0] a);
        return s.valid && s.we && (dst == a) && (a != '0);
    endfunction

    // Nearest matching stage decides; a result not yet produced yields RF.
    function automatic fwd_sel_t pick(input logic he, input logic hm, input logic hw,
                                      input logic [1:0] te, input logic [1:0] tm,
                                      input logic [1:0] tw);
        if (he) return (te == 2'd0) ? SEL_E : SEL_RF;
        if (hm) return (tm == 2'd0) ? SEL_M : SEL_RF;
        if (hw) return (tw == 2'd0) ? SEL_W : SEL_RF;
        return SEL_RF;
    endfunction

    assign w_d_src = d_src_addr;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [1:0] w_tuse;
            logic       w_he, w_hm, w_hw, w_em, w_ew;

            assign w_tuse = d_src_tuse[gi*2 +: 2];
            assign w_he   = hit(r_e, r_e_dst, w_d_src[gi]);
            assign w_hm   = hit(r_m, r_m_dst, w_d_src[gi]);
            assign w_hw   = hit(r_w, r_w_dst, w_d_src[gi]);
            assign w_hazard[gi] = (w_tuse != TUSE_NONE) &&
                                  ((w_he && (r_e.tnew > w_tuse)) ||
                                   (w_hm && (r_m.tnew > w_tuse)) ||
                                   (w_hw && (r_w.tnew > w_tuse)));
            assign fwd_d_sel[gi*2 +: 2] = pick(w_he, w_hm, w_hw, r_e.tnew, r_m.tnew, r_w.tnew);

            assign w_em = hit(r_m, r_m_dst, r_e_src[gi]);
            assign w_ew = hit(r_w, r_w_dst, r_e_src[gi]);
            assign fwd_e_sel[gi*2 +: 2] = pick(1'b0, w_em, w_ew, r_e.tnew, r_m.tnew, r_w.tnew);
        end
    endgenerate

    assign fwd_m_sel    = pick(1'b0, 1'b0, hit(r_w, r_w_dst, r_m_rt), r_e.tnew, r_m.tnew, r_w.tnew);
    assign w_data_stall = d_valid && (|w_hazard);
    assign stall        = w_data_stall || w_md_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e     <= '0;
            r_m     <= '0;
            r_w     <= '0;
            r_e_dst <= '0;
            r_m_dst <= '0;
            r_w_dst <= '0;
            r_e_src <= '0;
            r_m_rt  <= '0;
        end else begin
            if (stall) begin
                r_e     <= '0;
                r_e_dst <= '0;
                r_e_src <= '0;
            end else begin
                r_e     <= '{valid: d_valid, we: d_dst_we, tnew: d_dst_tnew};
                r_e_dst <= d_dst_addr;
                r_e_src <= w_d_src;
            end
            r_m     <= '{valid: r_e.valid, we: r_e.we, tnew: tnew_step(r_e.tnew)};
            r_m_dst <= r_e_dst;
            r_m_rt  <= r_e_src[RT_IDX];
            r_w     <= '{valid: r_m.valid, we: r_m.we, tnew: tnew_step(r_m.tnew)};
            r_w_dst <= r_m_dst;
        end
    end

`ifdef FWD_MD_UNIT_EN
    logic r_e_md_start, r_e_md_div;

    // The counter loads as the starting instruction leaves E, so hi/lo readers also wait on E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
        end else if (stall) begin
            r_e_md_start <= 1'b0;
            r_e_md_div   <= 1'b0;
        end else begin
            r_e_md_start <= d_valid && d_md_start;
            r_e_md_div   <= d_md_div;
        end
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_e_md_start),
        .i_div  (r_e_md_div),
        .o_busy (md_busy)
    );

    assign w_md_stall = d_valid && d_md_use && (md_busy || r_e_md_start);
`else
    assign md_busy    = 1'b0;
    assign w_md_stall = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Table-driven bench for fwd_stall_ctrl: per-cycle D-stage vectors with expected outputs checked via a scoreboard.
module tb_fwd_stall_ctrl;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
`ifdef FWD_MD_UNIT_EN
    localparam int EXP_MULT_BUSY = MULT_LAT;
    localparam int EXP_MID_BUSY  = 1;
`else
    localparam int EXP_MULT_BUSY = 0;
    localparam int EXP_MID_BUSY  = 0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [1:0] trs;
        logic [4:0] rt;
        logic [1:0] trt;
        logic [4:0] dst;
        logic       we;
        logic [1:0] tnew;
        logic       mds, mdd, mdu;
    } ins_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] d0, d1, e0, e1, m;
        logic       busy;
    } exp_t;

    typedef struct packed {
        ins_t i;
        exp_t x;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [9:0] d_src_addr;
    logic [3:0] d_src_tuse;
    logic [4:0] d_dst_addr;
    logic       d_dst_we;
    logic [1:0] d_dst_tnew;
    logic       d_md_start, d_md_div, d_md_use;
    logic       stall;
    logic [3:0] fwd_d_sel, fwd_e_sel;
    logic [1:0] fwd_m_sel;
    logic       md_busy;

    vec_t  vecs[$];
    string names[$];
    exp_t  sb_q[$];
    int    sb_idx[$];
    int    tests = 0;
    int    fails = 0;

    fwd_stall_ctrl #(
        .REG_AW(5), .NUM_SRC(2), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_src_addr(d_src_addr),
        .d_src_tuse(d_src_tuse), .d_dst_addr(d_dst_addr), .d_dst_we(d_dst_we),
        .d_dst_tnew(d_dst_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_use(d_md_use), .stall(stall), .fwd_d_sel(fwd_d_sel),
        .fwd_e_sel(fwd_e_sel), .fwd_m_sel(fwd_m_sel), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic ins_t I(int rs, int trs, int rt, int trt, int dst, int we, int tnew);
        ins_t r;
        r = '0;
        r.v = 1'b1; r.rs = 5'(rs); r.trs = 2'(trs); r.rt = 5'(rt); r.trt = 2'(trt);
        r.dst = 5'(dst); r.we = 1'(we); r.tnew = 2'(tnew);
        return r;
    endfunction

    function automatic ins_t NOP();
        ins_t r;
        r = '0;
        r.trs = 2'd3; r.trt = 2'd3;
        return r;
    endfunction

    function automatic ins_t MDI(ins_t base, int mds, int mdd, int mdu);
        ins_t r;
        r = base;
        r.mds = 1'(mds); r.mdd = 1'(mdd); r.mdu = 1'(mdu);
        return r;
    endfunction

    function automatic exp_t X(int st, int d0, int d1, int e0, int e1, int m);
        exp_t r;
        r.stall = 1'(st); r.d0 = 2'(d0); r.d1 = 2'(d1);
        r.e0 = 2'(e0); r.e1 = 2'(e1); r.m = 2'(m); r.busy = 1'b0;
        return r;
    endfunction

    function automatic exp_t XB(int st, int busy);
        exp_t r;
        r = X(st, 0, 0, 0, 0, 0);
        r.busy = 1'(busy);
        return r;
    endfunction

    task automatic add(input string nm, input ins_t i, input exp_t x);
        vec_t v;
        v.i = i;
        v.x = x;
        vecs.push_back(v);
        names.push_back(nm);
    endtask

    task automatic add_nops(input string nm, input int n);
        for (int k = 0; k < n; k++) add(nm, NOP(), X(0, 0, 0, 0, 0, 0));
    endtask

    task automatic drive(input ins_t i);
        d_valid    = i.v;
        d_src_addr = {i.rt, i.rs};
        d_src_tuse = {i.trt, i.trs};
        d_dst_addr = i.dst;
        d_dst_we   = i.we;
        d_dst_tnew = i.tnew;
        d_md_start = i.mds;
        d_md_div   = i.mdd;
        d_md_use   = i.mdu;
    endtask

    task automatic chk(input string nm, input string f, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %0s %0s: got %0d, required %0d", nm, f, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input exp_t x);
        chk(nm, "stall", int'(stall), int'(x.stall));
        chk(nm, "fwd_d_sel0", int'(fwd_d_sel[1:0]), int'(x.d0));
        chk(nm, "fwd_d_sel1", int'(fwd_d_sel[3:2]), int'(x.d1));
        chk(nm, "fwd_e_sel0", int'(fwd_e_sel[1:0]), int'(x.e0));
        chk(nm, "fwd_e_sel1", int'(fwd_e_sel[3:2]), int'(x.e1));
        chk(nm, "fwd_m_sel", int'(fwd_m_sel), int'(x.m));
        chk(nm, "md_busy", int'(md_busy), int'(x.busy));
    endtask

    initial begin
        int   busy_cycles;
        exp_t x;
        int   idx;
        ins_t mult_i;

        // A (addu $3; addu $4,$3,$3) .. L (lw then one-cycle-later reader)
        add("A_addu3", I(1, 1, 2, 1, 3, 1, 1), X(0, 0, 0, 0, 0, 0));
        add("A_addu4", I(3, 1, 3, 1, 4, 1, 1), X(0, 0, 0, 0, 0, 0));
        add("A_nop1",  NOP(),                  X(0, 0, 0, 1, 1, 0));
        add("A_nop2",  NOP(),                  X(0, 0, 0, 0, 0, 2));
        add_nops("A_nop3", 1);
        add("B_lw5",   I(1, 1, 0, 3, 5, 1, 2), X(0, 0, 0, 0, 0, 0));
        add("B_beq1",  I(5, 0, 0, 0, 0, 0, 0), X(1, 0, 0, 0, 0, 0));
        add("B_beq2",  I(5, 0, 0, 0, 0, 0, 0), X(1, 0, 0, 0, 0, 0));
        add("B_beq3",  I(5, 0, 0, 0, 0, 0, 0), X(0, 2, 0, 0, 0, 0));
        add_nops("B_nop", 3);
        add("C_lw5",   I(1, 1, 0, 3, 5, 1, 2), X(0, 0, 0, 0, 0, 0));
        add_nops("C_mid", 1);
        add("C_sw5",   I(2, 1, 5, 2, 0, 0, 0), X(0, 0, 0, 0, 0, 0));
        add("C_nop1",  NOP(),                  X(0, 0, 0, 0, 2, 0));
        add_nops("C_nop", 2);
        add("C2_lw6",  I(1, 1, 0, 3, 6, 1, 2), X(0, 0, 0, 0, 0, 0));
        add("C2_sw6",  I(2, 1, 6, 2, 0, 0, 0), X(0, 0, 0, 0, 0, 0));
        add_nops("C2_nop1", 1);
        add("C2_nop2", NOP(),                  X(0, 0, 0, 0, 0, 2));
        add_nops("C2_nop3", 1);
        add("D_jal",   I(0, 3, 0, 3, 31, 1, 0), X(0, 0, 0, 0, 0, 0));
        add("D_jr31",  I(31, 0, 0, 3, 0, 0, 0), X(0, 3, 0, 0, 0, 0));
        add("D_nop1",  NOP(),                   X(0, 0, 0, 1, 0, 0));
        add_nops("D_nop", 2);
        add("E_wr0",   I(1, 1, 2, 1, 0, 1, 1), X(0, 0, 0, 0, 0, 0));
        add("E_rd0",   I(0, 0, 0, 0, 7, 1, 1), X(0, 0, 0, 0, 0, 0));
        add_nops("E_nop", 3);
        add("F_w1",    I(1, 1, 2, 1, 8, 1, 1), X(0, 0, 0, 0, 0, 0));
        add("F_w2",    I(1, 1, 2, 1, 8, 1, 1), X(0, 0, 0, 0, 0, 0));
        add_nops("F_gap", 1);
        add("F_rd8",   I(8, 0, 8, 1, 9, 1, 1), X(0, 1, 1, 0, 0, 0));
        add("F_nop1",  NOP(),                  X(0, 0, 0, 2, 2, 0));
        add_nops("F_nop", 2);
        add("G_lw10",  I(1, 1, 0, 3, 10, 1, 2), X(0, 0, 0, 0, 0, 0));
        add("G_unused", I(10, 3, 0, 3, 0, 0, 0), X(0, 0, 0, 0, 0, 0));
        add_nops("G_nop", 3);
        add("H_addu11", I(1, 1, 2, 1, 11, 1, 1), X(0, 0, 0, 0, 0, 0));
        add("H_beq1",  I(11, 0, 0, 0, 0, 0, 0), X(1, 0, 0, 0, 0, 0));
        add("H_beq2",  I(11, 0, 0, 0, 0, 0, 0), X(0, 1, 0, 0, 0, 0));
        add("H_nop1",  NOP(),                   X(0, 0, 0, 2, 0, 0));
        add_nops("H_nop", 2);
        add("L_lw13",  I(1, 1, 0, 3, 13, 1, 2), X(0, 0, 0, 0, 0, 0));
        add("L_add1",  I(13, 1, 0, 3, 14, 1, 1), X(1, 0, 0, 0, 0, 0));
        add("L_add2",  I(13, 1, 0, 3, 14, 1, 1), X(0, 0, 0, 0, 0, 0));
        add("L_nop1",  NOP(),                    X(0, 0, 0, 2, 0, 0));
        add_nops("L_nop", 2);
        add("M_div",   MDI(I(1, 1, 2, 1, 0, 0, 0), 1, 1, 0), XB(0, 0));
`ifdef FWD_MD_UNIT_EN
        add("M_mfhi_e", MDI(I(0, 3, 0, 3, 12, 1, 1), 0, 0, 1), XB(1, 0));
        for (int c = 0; c < DIV_LAT; c++)
            add("M_mfhi_b", MDI(I(0, 3, 0, 3, 12, 1, 1), 0, 0, 1), XB(1, 1));
`endif
        add("M_mfhi",  MDI(I(0, 3, 0, 3, 12, 1, 1), 0, 0, 1), XB(0, 0));
        add_nops("M_nop", 3);

        // Reset state: a would-be hazard reader is presented while reset holds
        reset = 1'b1;
        drive(I(5, 0, 5, 0, 1, 1, 1));
        @(negedge clk);
        #2;
        chk_all("reset_state", X(0, 0, 0, 0, 0, 0));
        $display("[TB] reset_state stall=%0b busy=%0b", stall, md_busy);
        @(negedge clk);
        reset = 1'b0;
        drive(NOP());

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].i);
            sb_q.push_back(vecs[k].x);
            sb_idx.push_back(k);
            #2;
            x   = sb_q.pop_front();
            idx = sb_idx.pop_front();
            chk_all(names[idx], x);
            $display("[TB] %0s stall=%0b d=%0d/%0d e=%0d/%0d m=%0d busy=%0b", names[idx], stall,
                     fwd_d_sel[1:0], fwd_d_sel[3:2], fwd_e_sel[1:0], fwd_e_sel[3:2], fwd_m_sel, md_busy);
        end

        // Asynchronous reset drops a pending load-use stall without a clock edge
        @(negedge clk);
        drive(I(1, 1, 0, 3, 5, 1, 2));
        @(negedge clk);
        drive(I(5, 0, 0, 0, 0, 0, 0));
        #2;
        chk("async_rst", "stall_before", int'(stall), 1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst", "stall_after", int'(stall), 0);
        $display("[TB] async_rst stall=%0b", stall);
        @(negedge clk);
        reset = 1'b0;
        drive(NOP());

        // Multiply occupancy length, then a reset in the middle of a second multiply
        mult_i = MDI(I(1, 1, 2, 1, 0, 0, 0), 1, 0, 0);
        @(negedge clk);
        drive(mult_i);
        @(negedge clk);
        drive(NOP());
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #2;
            if (md_busy === 1'b1) busy_cycles++;
        end
        chk("mult", "busy_cycles", busy_cycles, EXP_MULT_BUSY);
        $display("[TB] mult busy_cycles=%0d", busy_cycles);

        @(negedge clk);
        drive(mult_i);
        @(negedge clk);
        drive(NOP());
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("mult_rst", "busy_before", int'(md_busy), EXP_MID_BUSY);
        #1 reset = 1'b1;
        #1;
        chk("mult_rst", "busy_after", int'(md_busy), 0);
        chk("mult_rst", "stall_after", int'(stall), 0);
        $display("[TB] mult_rst busy=%0b", md_busy);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
